uart_tx_sched: RTL
==================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 1, meaning clocks per serial bit.
REQ-002 The block SHALL have parameter FRAME_BITS, default 10, meaning bits per frame (start + 8 data + stop).
REQ-003 The block SHALL have parameter GAP_CYCLES, default 1, meaning idle clocks enforced between frames (0 allowed).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid, input, 4 bits: per-requester byte-pending flag.
REQ-007 The block SHALL have port req_data, input, 32 bits: packed bytes; requester i occupies bits [8i+7:8i].
REQ-008 The block SHALL have port req_ready, output, 4 bits: one-hot accept strobe; at most one bit high.
REQ-009 The block SHALL have port ser_start, output, 1 bit: one-cycle start pulse to the serializer.
REQ-010 The block SHALL have port ser_data, output, 8 bits: byte presented to the serializer.
REQ-011 The block SHALL have port grant_id, output, 2 bits: index of the requester owning the current frame.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse in the last SEND cycle.

Function
REQ-014 The FSM SHALL have states IDLE, START, SEND and GAP.
REQ-015 In IDLE with any req_valid set, the block SHALL select a winner, drive req_ready[winner]=1 combinationally in that cycle, latch its byte into ser_data and its index into grant_id, and go to START.
REQ-016 A transfer SHALL occur only in a cycle where req_valid[i] and req_ready[i] are both high; a valid dropped before ready SHALL cause no transfer and no state change.
REQ-017 req_ready SHALL be all-zero outside IDLE and in IDLE when req_valid is zero.
REQ-018 START SHALL last exactly one cycle with ser_start=1, then go to SEND.
REQ-019 SEND SHALL last exactly FRAME_BITS*BAUD_DIV cycles, counted by a down-counter at least 16 bits wide, and assert frame_done in its final cycle.
REQ-020 After SEND, the FSM SHALL enter GAP for GAP_CYCLES cycles, or go directly to IDLE when GAP_CYCLES is 0.
REQ-021 ser_data and grant_id SHALL stay stable from START through the end of GAP.
REQ-022 Accept-to-accept spacing SHALL be 2+FRAME_BITS*BAUD_DIV+GAP_CYCLES cycles (13 with defaults).
REQ-023 Round-robin arbitration SHALL search from (last_grant+1) mod 4 upward with wrap-around; last_grant SHALL update only on a transfer.
REQ-024 Requests that arrive while busy SHALL be held pending by the requester; the block SHALL not drop or queue them.

Reset
REQ-025 With rst_n low, the block SHALL enter IDLE immediately, with req_ready=0, ser_start=0, ser_data=8'h00, grant_id=0, busy=0, frame_done=0, counters=0 and last_grant=3 (requester 0 has first priority).
REQ-026 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse; after release the FSM SHALL resume arbitration from IDLE on the first rising clk edge.

Configuration
REQ-027 When UART_TX_SCHED_PRIO_EN is defined, requester 0 SHALL win whenever req_valid[0] is set, and requesters 1-3 SHALL be served round-robin among themselves.
REQ-028 When UART_TX_SCHED_PRIO_EN is not defined, all four requesters SHALL be served by pure round-robin per REQ-023.

Verification
REQ-029 Reset, then req_valid=4'b0001 with byte 0xA5 -> req_ready=4'b0001 in that cycle, ser_start next cycle with ser_data=0xA5, frame_done 10 cycles later, busy low 13 cycles after the accept.
REQ-030 req_valid=4'b1111 held with defaults -> grants 0,1,2,3,0, each 13 cycles apart, with grant_id matching each grant.
REQ-031 With UART_TX_SCHED_PRIO_EN defined and req_valid=4'b1111 held -> every grant goes to 0; with req_valid=4'b1110 -> grants 1,2,3,1.
REQ-032 rst_n pulsed low during cycle 5 of SEND -> outputs reach reset values asynchronously, no frame_done, and the next grant goes to requester 0.
REQ-033 BAUD_DIV=4, GAP_CYCLES=0 -> SEND lasts 40 cycles, and the next accept comes 42 cycles after the previous one.
REQ-034 req_valid[2] raised while busy and dropped before IDLE -> req_ready[2] never asserts and no frame is started.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// ---------------------------------------------------------------------------
// uart_tx_sched_if
// Purpose : groups the requester handshake and the serializer-facing outputs
//           of uart_tx_sched into one bundle.
// Signals : req_valid[3:0]  per-requester byte-pending flag
//           req_data[31:0]  packed bytes, requester i in bits [8i+7:8i]
//           req_ready[3:0]  one-hot accept strobe
//           ser_start       one-cycle start pulse to the serializer
//           ser_data[7:0]   byte presented to the serializer
//           grant_id[1:0]   requester owning the current frame
//           busy            scheduler not idle
//           frame_done      pulse in the last send cycle
// Modports: master - requester/serializer side (drives req_valid/req_data)
//           slave  - scheduler side (uart_tx_sched)
// ---------------------------------------------------------------------------
interface uart_tx_sched_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        ser_start;
  logic [7:0]  ser_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        frame_done;

  modport master (
    output req_valid, req_data,
    input  req_ready, ser_start, ser_data, grant_id, busy, frame_done
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, ser_start, ser_data, grant_id, busy, frame_done
  );
endinterface

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
// Purpose : arbitrates four byte requesters onto one UART serializer. Each
//           accepted byte produces a START cycle, a SEND phase of
//           FRAME_BITS*BAUD_DIV cycles and an optional GAP of idle cycles.
// Ports   : clk    - clock, all state changes on rising edge
//           rst_n  - asynchronous active-low reset
//           bus    - uart_tx_sched_if.slave (requests in, serializer out)
// Params  : BAUD_DIV   clocks per serial bit
//           FRAME_BITS bits per frame
//           GAP_CYCLES idle clocks between frames (0 allowed)
// Config  : define UART_TX_SCHED_PRIO_EN to give requester 0 absolute
//           priority; requesters 1-3 then share round-robin. Without it all
//           four requesters are served pure round-robin.
// ---------------------------------------------------------------------------
module uart_tx_sched #(
  parameter int BAUD_DIV   = 1,
  parameter int FRAME_BITS = 10,
  parameter int GAP_CYCLES = 1
) (
  input logic            clk,
  input logic            rst_n,
  uart_tx_sched_if.slave bus
);

  localparam int SEND_LEN = FRAME_BITS * BAUD_DIV;
  localparam int MAX_LOAD = (SEND_LEN > GAP_CYCLES) ? SEND_LEN : GAP_CYCLES;
  localparam int CNT_W    = ($clog2(MAX_LOAD + 1) > 16) ? $clog2(MAX_LOAD + 1) : 16;
  localparam logic [CNT_W-1:0] SEND_LOAD = CNT_W'(SEND_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       last_grant;
  logic [1:0]       winner;
  logic [1:0]       idx;
  logic             found;
  logic             transfer;
  logic [3:0]       ready_d;
  logic [7:0]       data_q;
  logic [1:0]       gid_q;

  // Arbiter: walk the requesters starting just after the last grant so the
  // most recently served one is considered last.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    idx    = '0;
`ifdef UART_TX_SCHED_PRIO_EN
    if (bus.req_valid[0]) begin
      winner = 2'd0;
      found  = 1'b1;
    end
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!found && idx != 2'd0 && bus.req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
`else
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!found && bus.req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
`endif
  end

  // Next-state logic. The counter is reused for SEND and GAP; it is loaded
  // with length-1 on entry so the phase ends when it reads zero.
  // req_ready is gated with rst_n so it stays low while reset is held.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    ready_d  = '0;
    transfer = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && found) begin
          transfer        = 1'b1;
          ready_d[winner] = 1'b1;
          state_d         = START;
        end
      end
      START: begin
        state_d = SEND;
        cnt_d   = SEND_LOAD;
      end
      SEND: begin
        if (cnt == '0) begin
          state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; byte, grant index and round-robin pointer are captured
  // only on an actual transfer so they hold steady for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      data_q     <= 8'h00;
      gid_q      <= 2'd0;
      last_grant <= 2'd3;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (transfer) begin
        data_q     <= bus.req_data[{winner, 3'b000} +: 8];
        gid_q      <= winner;
        last_grant <= winner;
      end
    end
  end

  assign bus.req_ready  = ready_d;
  assign bus.ser_start  = (state == START);
  assign bus.frame_done = (state == SEND) && (cnt == '0);
  assign bus.busy       = (state != IDLE);
  assign bus.ser_data   = data_q;
  assign bus.grant_id   = gid_q;

endmodule
